// File: rtl/snake_dir_ctrl_pkg.sv
// Shared types for the Snake direction front end: headings, FSM states,
// button priority indices and heading helper functions.
package snake_ctrl_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MV_UP    = 3'd1,
        MV_DOWN  = 3'd2,
        MV_LEFT  = 3'd3,
        MV_RIGHT = 3'd4
    } state_e;

    // Lower index wins when several presses land in one cycle
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int NUM_BTN   = 4;

    function automatic dir_e opposite(dir_e d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            RIGHT:   return LEFT;
            default: return NONE;
        endcase
    endfunction

    function automatic dir_e state_dir(state_e s);
        case (s)
            MV_UP:    return UP;
            MV_DOWN:  return DOWN;
            MV_LEFT:  return LEFT;
            MV_RIGHT: return RIGHT;
            default:  return NONE;
        endcase
    endfunction

    function automatic state_e dir_state(dir_e d);
        case (d)
            UP:      return MV_UP;
            DOWN:    return MV_DOWN;
            LEFT:    return MV_LEFT;
            RIGHT:   return MV_RIGHT;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Button inputs and heading/tick outputs of the Snake direction front end.
// SNAKE_PAUSE_EN adds the paused status signal.
interface snake_dir_ctrl_if;
    logic up_button;
    logic down_button;
    logic left_button;
    logic right_button;
    logic up;
    logic down;
    logic left;
    logic right;
    logic slow_clk;
    logic step;
`ifdef SNAKE_PAUSE_EN
    logic paused;

    modport master (
        output up_button, down_button, left_button, right_button,
        input  up, down, left, right, slow_clk, step, paused
    );
    modport slave (
        input  up_button, down_button, left_button, right_button,
        output up, down, left, right, slow_clk, step, paused
    );
`else
    modport master (
        output up_button, down_button, left_button, right_button,
        input  up, down, left, right, slow_clk, step
    );
    modport slave (
        input  up_button, down_button, left_button, right_button,
        output up, down, left, right, slow_clk, step
    );
`endif
endinterface

// File: rtl/snake_dir_ctrl_button_debouncer.sv
// One push button: 2-flop synchronizer, stability counter, press pulse.
// level_o is active-high pressed; press_o pulses with its rising edge.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pressed;

    assign pressed = ~sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any cycle agreeing with the stable level restarts the count
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (pressed != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = pressed;
                press_d = pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction front end: debounced buttons to a registered one-hot
// heading plus the slow game tick. SNAKE_PAUSE_EN adds up+down pause.
module snake_dir_ctrl
    import snake_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_DIV        = 1250000,
    parameter int CNT_W           = 24
) (
    input  logic            clk,
    input  logic            reset,
    snake_dir_ctrl_if.slave io
);

    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

    logic [NUM_BTN-1:0] btn_n;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;

    assign btn_n[BTN_UP]    = io.up_button;
    assign btn_n[BTN_DOWN]  = io.down_button;
    assign btn_n[BTN_LEFT]  = io.left_button;
    assign btn_n[BTN_RIGHT] = io.right_button;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .btn_n_i(btn_n[i]),
            .level_o(level[i]),
            .press_o(press[i])
        );
    end

    logic combo;
    logic run;

`ifdef SNAKE_PAUSE_EN
    logic paused_q;
    logic paused_d;
    logic lvl_unused;

    assign combo      = level[BTN_UP] & level[BTN_DOWN]
                      & (press[BTN_UP] | press[BTN_DOWN]);
    assign run        = ~paused_q;
    assign paused_d   = paused_q ^ combo;
    assign lvl_unused = ^level[BTN_RIGHT:BTN_LEFT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) paused_q <= 1'b0;
        else       paused_q <= paused_d;
    end

    assign io.paused = paused_q;
`else
    logic lvl_unused;

    assign combo      = 1'b0;
    assign run        = 1'b1;
    assign lvl_unused = ^level;
`endif

    // Slow tick
    logic [CNT_W-1:0] tick_q;
    logic [CNT_W-1:0] tick_d;
    logic             slow_q;
    logic             slow_d;
    logic             step_q;
    logic             step_d;
    logic             wrap;

    always_comb begin
        wrap   = run && (tick_q == TICK_MAX);
        tick_d = tick_q;
        if (wrap)     tick_d = '0;
        else if (run) tick_d = tick_q + 1'b1;
        slow_d = slow_q ^ wrap;
        step_d = wrap & ~slow_q;
    end

    // Heading FSM and pending press
    state_e     state_q;
    state_e     state_d;
    dir_e       pend_q;
    dir_e       pend_d;
    dir_e       evt;
    dir_e       head;
    logic       accept;
    logic [3:0] dir_q;
    logic [3:0] dir_d;

    always_comb begin
        evt = NONE;
        if (press[BTN_UP])         evt = UP;
        else if (press[BTN_DOWN])  evt = DOWN;
        else if (press[BTN_LEFT])  evt = LEFT;
        else if (press[BTN_RIGHT]) evt = RIGHT;
        head   = state_dir(state_q);
        accept = run && !combo && (evt != NONE)
              && (evt != head) && (evt != opposite(head));
    end

    // Events seen on a step cycle wait for the next step
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (step_q && (pend_q != NONE)) begin
            state_d = dir_state(pend_q);
            pend_d  = NONE;
        end
        if (accept) pend_d = evt;
    end

    always_comb begin
        dir_d = 4'b0000;
        case (state_d)
            MV_UP:    dir_d = 4'b1000;
            MV_DOWN:  dir_d = 4'b0100;
            MV_LEFT:  dir_d = 4'b0010;
            MV_RIGHT: dir_d = 4'b0001;
            default:  dir_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q  <= '0;
            slow_q  <= 1'b0;
            step_q  <= 1'b0;
            state_q <= IDLE;
            pend_q  <= NONE;
            dir_q   <= 4'b0000;
        end else begin
            tick_q  <= tick_d;
            slow_q  <= slow_d;
            step_q  <= step_d;
            state_q <= state_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
        end
    end

    assign io.up       = dir_q[3];
    assign io.down     = dir_q[2];
    assign io.left     = dir_q[1];
    assign io.right    = dir_q[0];
    assign io.slow_clk = slow_q;
    assign io.step     = step_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed + random bench for snake_dir_ctrl against a behavioural model.
// Build with SNAKE_PAUSE_EN defined to also exercise the pause combo.
module tb_snake_dir_ctrl;

    localparam int DEB = 4;
    localparam int TD  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    snake_dir_ctrl_if io();

    snake_dir_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV       (TD),
        .CNT_W          (24)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (io.slave)
    );

    always #5 clk = ~clk;

    // Model: buttons 0..3 = up,down,left,right; heading 0=none, 1..4 = button+1
    logic [3:0] btn_n;
    bit         m_s1[4];
    bit         m_s2[4];
    bit         m_lvl[4];
    bit         m_prs[4];
    int         m_win[4][$];
    int         m_act;
    int         m_head;
    int         m_pend;
    bit         m_step;
    bit         m_paused;

    function automatic int opp(int d);
        case (d)
            1: return 2;
            2: return 1;
            3: return 4;
            4: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] onehot(int d);
        case (d)
            1: return 32'b1000;
            2: return 32'b0100;
            3: return 32'b0010;
            4: return 32'b0001;
            default: return 32'b0000;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_s1[b]  = 1'b1;
            m_s2[b]  = 1'b1;
            m_lvl[b] = 1'b0;
            m_prs[b] = 1'b0;
            m_win[b].delete();
        end
        m_act    = 0;
        m_head   = 0;
        m_pend   = 0;
        m_step   = 1'b0;
        m_paused = 1'b0;
    endtask

    task automatic model_edge();
        bit run;
        bit combo;
        bit all_diff;
        bit ps;
        int ev;
        run   = !m_paused;
        combo = 1'b0;
        ev    = 0;
`ifdef SNAKE_PAUSE_EN
        combo = m_lvl[0] && m_lvl[1] && (m_prs[0] || m_prs[1]);
`endif
        if (run && !combo)
            for (int b = 3; b >= 0; b--)
                if (m_prs[b]) ev = b + 1;
        if (ev == m_head || ev == opp(m_head)) ev = 0;
        if (m_step && m_pend != 0) begin
            m_head = m_pend;
            m_pend = 0;
        end
        if (ev != 0) m_pend = ev;
        if (combo) m_paused = !m_paused;
        if (run) m_act++;
        m_step = run && (m_act % (2 * TD) == TD);
        // A level is accepted once the last DEB synced samples all disagree
        for (int b = 0; b < 4; b++) begin
            ps = !m_s2[b];
            m_win[b].push_back(int'(ps));
            if (m_win[b].size() > DEB) void'(m_win[b].pop_front());
            all_diff = (m_win[b].size() == DEB);
            foreach (m_win[b][j])
                if (m_win[b][j] == int'(m_lvl[b])) all_diff = 1'b0;
            m_prs[b] = 1'b0;
            if (all_diff) begin
                m_lvl[b] = ps;
                m_prs[b] = ps;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = btn_n[b];
        end
    endtask

    task automatic check_outputs();
        chk("dir", {28'b0, io.up, io.down, io.left, io.right}, onehot(m_head));
        chk("slow", 32'(io.slow_clk), 32'((m_act / TD) % 2));
        chk("step", 32'(io.step), 32'(m_step));
`ifdef SNAKE_PAUSE_EN
        chk("paused", 32'(io.paused), 32'(m_paused));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_btn(logic [3:0] mask);
        btn_n           = ~mask;
        io.up_button    = btn_n[0];
        io.down_button  = btn_n[1];
        io.left_button  = btn_n[2];
        io.right_button = btn_n[3];
    endtask

    task automatic press(logic [3:0] mask, int n);
        set_btn(mask);
        repeat (n) cyc();
        set_btn(4'b0000);
    endtask

    task automatic idle(int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) cyc();
        reset = 1'b0;
    endtask

    task automatic wait_step();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            seen = io.step;
        end
        chk("step_seen", 32'(seen), 32'd1);
    endtask

    task automatic chk_dir(string tag, logic [3:0] exp);
        chk(tag, {28'b0, io.up, io.down, io.left, io.right}, {28'b0, exp});
    endtask

    initial begin
        int lat;
        logic [3:0] mask;
        set_btn(4'b0000);
        model_reset();

        // Reset state
        do_reset(3);
        chk_dir("rst_dir", 4'b0000);
        chk("rst_slow", 32'(io.slow_clk), 32'd0);
        chk("rst_step", 32'(io.step), 32'd0);

        // Reset mid-count at cycle 37, then latency to the first step
        idle(36);
        do_reset(3);
        chk_dir("rst2_dir", 4'b0000);
        chk("rst2_slow", 32'(io.slow_clk), 32'd0);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cyc();
            if (io.step) lat = i;
        end
        chk("rst_step_lat", 32'(lat), 32'd8);

        // Glitch shorter than the debounce window
        press(4'b1000, 3);
        idle(40);
        chk_dir("glitch_dir", 4'b0000);

        // Real press
        press(4'b1000, 10);
        wait_step();
        wait_step();
        cyc();
        chk_dir("press_right", 4'b0001);

        // Reversal rejected
        press(4'b0100, 10);
        wait_step();
        wait_step();
        cyc();
        chk_dir("reverse_rej", 4'b0001);

        // Up applied at step N, left pressed afterwards applied at N+1
        wait_step();
        press(4'b0001, 8);
        wait_step();
        cyc();
        chk_dir("turn_up", 4'b1000);
        press(4'b0100, 8);
        wait_step();
        cyc();
        chk_dir("turn_left", 4'b0010);

        // Two presses within one tick: the later one wins
        press(4'b0001, 6);
        press(4'b0010, 6);
        wait_step();
        cyc();
        chk_dir("last_wins", 4'b0100);

        // Hold down from MV_LEFT
        press(4'b0100, 8);
        wait_step();
        wait_step();
        cyc();
        chk_dir("to_left", 4'b0010);
        press(4'b0010, 100);
        chk_dir("hold_down", 4'b0100);
        idle(40);
        chk_dir("hold_stay", 4'b0100);

        // Simultaneous up+right from IDLE
        do_reset(2);
        press(4'b1001, 8);
        wait_step();
        wait_step();
        cyc();
        chk_dir("simul_up", 4'b1000);

`ifdef SNAKE_PAUSE_EN
        begin
            logic s0;
            press(4'b0011, 8);
            chk("pause_on", 32'(io.paused), 32'd1);
            s0 = io.slow_clk;
            for (int i = 0; i < 50; i++) begin
                cyc();
                chk("pause_slow", 32'(io.slow_clk), 32'(s0));
            end
            press(4'b0011, 8);
            chk("pause_off", 32'(io.paused), 32'd0);
            idle(40);
            chk_dir("pause_dir", 4'b1000);
        end
`endif

        // Random presses against the model
        for (int seg = 0; seg < 200; seg++) begin
            mask = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            press(mask, $urandom_range(1, 14));
            if (seg % 50 == 49) do_reset(2);
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
